regfile: RTL and testbench

- Synchronous single-port-address register file: 256 entries x 8 bits by default, one shared address bus, independent read and write enables.
- Writes commit on the rising clock edge.
- Reads are registered, with one-cycle latency, onto a held output.
- Used as a generic CPU/peripheral-visible configuration/status store.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_entry.sv | 40 ++++
 rtl/regfile.sv | 88 ++++++++
 tb/tb_regfile.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, reset value and handy typedefs for the regfile block.
package regfile_pkg;

  localparam int REGFILE_ADDR_W = 8;
  localparam int REGFILE_DATA_W = 8;
  localparam int REGFILE_DEPTH  = 256;

  localparam logic [REGFILE_DATA_W-1:0] REGFILE_RESET_VAL = 8'h00;

  typedef logic [REGFILE_ADDR_W-1:0] addr_t;
  typedef logic [REGFILE_DATA_W-1:0] data_t;

endpackage : regfile_pkg

// File: rtl/regfile_entry.sv
// One storage word of the regfile: async active-high reset to RESET_VAL,
// loads d when its decoded write enable is high, otherwise holds.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int                 DATA_W    = REGFILE_DATA_W,
  parameter logic [DATA_W-1:0]  RESET_VAL = REGFILE_RESET_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Next value: new data on a decoded write, otherwise keep the stored word.
  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop; reset wins over any write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : regfile_entry

// File: rtl/regfile.sv
// Single-address register file: DEPTH words of DATA_W bits, shared address,
// independent write/read enables, registered read data held when idle.
// Optional build macro REGFILE_WRITE_BYPASS_EN: a same-address read+write
// returns the incoming din (write-first) instead of the old contents.
module regfile
  import regfile_pkg::*;
#(
  parameter int                ADDR_W    = REGFILE_ADDR_W,
  parameter int                DATA_W    = REGFILE_DATA_W,
  parameter int                DEPTH     = REGFILE_DEPTH,
  parameter logic [DATA_W-1:0] RESET_VAL = REGFILE_RESET_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              wen,
  input  logic              ren,
  output logic [DATA_W-1:0] dout
);

  // Depth widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic              addr_in_range_s;
  logic [DEPTH-1:0]  entry_we_s;
  logic [DATA_W-1:0] mem_s [DEPTH];
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  assign addr_in_range_s = ({1'b0, addr} < DEPTH_W);

  // Storage array with a one-hot write decode per entry; wen low forces
  // every enable low regardless of address/data values.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_we_s[gi] = wen & addr_in_range_s & (addr == ADDR_W'(gi));

    regfile_entry #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_entry (
      .clk (clk),
      .rst (rst),
      .we  (entry_we_s[gi]),
      .d   (din),
      .q   (mem_s[gi])
    );
  end : g_entry

  // AND-OR read mux; an out-of-range address matches no entry and reads 0.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rd_data_s = rd_data_s | ({DATA_W{addr == ADDR_W'(i)}} & mem_s[i]);
    end
  end

  // Next read data: load on ren, otherwise hold the last value.
  always_comb begin
    dout_d = dout_q;
    if (ren) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wen && addr_in_range_s) begin
        dout_d = din;
      end else begin
        dout_d = rd_data_s;
      end
`else
      dout_d = rd_data_s;
`endif
    end else begin
      dout_d = dout_q;
    end
  end

  // Registered read port; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= RESET_VAL;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed steps from the test plan plus a
// randomized phase, all compared against a plain array reference model.
module tb_regfile;

  localparam int DEPTH = 256;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] din;
  logic       wen;
  logic       ren;
  logic [7:0] dout;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] exp_dout;
  int         checks;
  int         errors;

  regfile dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .din  (din),
    .wen  (wen),
    .ren  (ren),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    exp_dout = 8'h00;
  endtask

  // One clock of stimulus; the model applies the edge, then dout is compared.
  task automatic step(input logic w, input logic r, input logic [7:0] a,
                      input logic [7:0] d, input string tag);
    @(negedge clk);
    wen = w; ren = r; addr = a; din = d;
    @(posedge clk);
    if (r) begin
      if (int'(a) >= DEPTH) exp_dout = 8'h00;
`ifdef REGFILE_WRITE_BYPASS_EN
      else if (w) exp_dout = d;
`endif
      else exp_dout = ref_mem[a];
    end
    if (w && int'(a) < DEPTH) ref_mem[a] = d;
    #1;
    check(tag, dout, exp_dout);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = 8'h00; din = 8'h00;
    model_reset();

    // Reset state, before and after a clock edge under reset.
    #2;
    check("reset_dout_t0", dout, 8'h00);
    @(posedge clk); #1;
    check("reset_dout_edge", dout, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Read 0..3 after reset.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i), 8'h00, "rd_after_reset");

    // Write 0..3, idle 10 cycles, read back.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(i), 8'(2 * i), "wr_0_3_hold");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 8'h00, "idle_hold");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i), 8'h00, "rdback_0_3");
    check("rdback_3_value", dout, 8'h06);

    // Top address and no aliasing onto address 0.
    step(1'b1, 1'b0, 8'hFF, 8'hA5, "wr_ff");
    step(1'b0, 1'b1, 8'hFF, 8'h00, "rd_ff");
    check("rd_ff_value", dout, 8'hA5);
    step(1'b0, 1'b1, 8'h00, 8'h00, "rd_00_after_ff");
    step(1'b0, 1'b1, 8'hFF, 8'h00, "rd_ff_again");

    // ren=0 with wandering addr/din: dout holds A5.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 8'($urandom), 8'($urandom), "hold_a5");
    check("hold_a5_value", dout, 8'hA5);
    @(negedge clk);
    addr = 8'bx; din = 8'bx; wen = 1'b0; ren = 1'b0;
    @(posedge clk); #1;
    check("hold_x_inputs", dout, 8'hA5);

    // Simultaneous read and write at the same address.
    step(1'b1, 1'b0, 8'h10, 8'h11, "wr_10_old");
    step(1'b1, 1'b1, 8'h10, 8'h22, "rw_same_addr");
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rw_same_bypass", dout, 8'h22);
`else
    check("rw_same_rbw", dout, 8'h11);
`endif
    step(1'b0, 1'b1, 8'h10, 8'h00, "rd_10_new");
    check("rd_10_new_value", dout, 8'h22);

    // Simultaneous read and write at different addresses.
    step(1'b1, 1'b1, 8'h20, 8'h5A, "rw_diff_addr");
    step(1'b1, 1'b1, 8'h21, 8'h00, "rw_diff_addr2");

    // Randomized traffic, biased to a small address window for reuse.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      step(1'($urandom), 1'($urandom), ra, 8'($urandom), "random");
    end

    // Asynchronous reset mid-cycle after writing 0x3C to address 5.
    step(1'b1, 1'b0, 8'h05, 8'h3C, "wr_5_3c");
    step(1'b0, 1'b1, 8'h05, 8'h00, "rd_5_3c");
    check("rd_5_3c_value", dout, 8'h3C);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_dout", dout, 8'h00);
    check("async_rst_mem5", dut.mem_s[5], 8'h00);
    @(negedge clk);
    wen = 1'b1; ren = 1'b1; addr = 8'h05; din = 8'h77;
    @(posedge clk); #1;
    check("rst_blocks_write", dut.mem_s[5], 8'h00);
    check("rst_blocks_read", dout, 8'h00);
    @(negedge clk);
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    step(1'b0, 1'b1, 8'h05, 8'h00, "post_rst_rd_5");
    step(1'b0, 1'b1, 8'h10, 8'h00, "post_rst_rd_10");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile
